// File: rtl/seg7_scan_capture_if.sv
// rtl/seg7_scan_capture_if.sv - display bus and capture result bundle for seg7_scan_capture
interface seg7_scan_capture_if #(
  parameter int DIGITS = 4,
  parameter int IDX_W  = 2
);
  logic [6:0]          hex;
  logic [DIGITS-1:0]   dig_n;
  logic [4*DIGITS-1:0] bcd_out;
  logic [DIGITS-1:0]   valid;
  logic                upd;
  logic [IDX_W-1:0]    upd_idx;
  logic                err;
  logic [7:0]          err_cnt;

  // Drives the display pins and observes the captured results
  modport master (
    output hex, dig_n,
    input  bcd_out, valid, upd, upd_idx, err, err_cnt
  );

  // The capture block: reads the display pins, presents captured results
  modport slave (
    input  hex, dig_n,
    output bcd_out, valid, upd, upd_idx, err, err_cnt
  );
endinterface

// File: rtl/seg7_scan_capture.sv
// rtl/seg7_scan_capture.sv - recovers per-digit codes from a multiplexed active-low 7-segment bus
module seg7_scan_capture #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int IDX_W         = 2
) (
  input logic              clk,
  input logic              rst_n,
  seg7_scan_capture_if.slave bus
);

  localparam int CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_CYCLES - 2);
  localparam logic [DIGITS-1:0] DIG_ONE  = DIGITS'(1);

  typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;

  // Synchroniser stages and previous-sample register
  logic [6:0]        hex_m_q, hex_s_q, hex_p_q;
  logic [DIGITS-1:0] dig_m_q, dig_s_q, dig_p_q;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [4*DIGITS-1:0] bcd_q;
  logic [DIGITS-1:0]   valid_q;
  logic                upd_q, err_q;
  logic [IDX_W-1:0]    upd_idx_q;
  logic [7:0]          err_cnt_q;

  logic              match, onehot, legal, capture;
  logic [DIGITS-1:0] strobe;
  logic [IDX_W-1:0]  idx;
  logic [3:0]        code;

  // Sample comparison, strobe decode, segment decode and stability count
  always_comb begin
    match  = (hex_s_q == hex_p_q) && (dig_s_q == dig_p_q);
    strobe = ~dig_s_q;
    onehot = (strobe != '0) && ((strobe & (strobe - DIG_ONE)) == '0);
    idx    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (strobe[i]) idx = IDX_W'(i);
    end
    legal = 1'b1;
    code  = 4'h0;
    case (hex_s_q)
      7'b1000000: code = 4'h0;
      7'b1111001: code = 4'h1;
      7'b0100100: code = 4'h2;
      7'b0110000: code = 4'h3;
      7'b0011001: code = 4'h4;
      7'b0010010: code = 4'h5;
      7'b0000010: code = 4'h6;
      7'b1111000: code = 4'h7;
      7'b0000000: code = 4'h8;
      7'b0010000: code = 4'h9;
      7'b0111111: code = 4'hF;
      7'b1111111: code = 4'hE;
      default:    legal = 1'b0;
    endcase
    if (!match || !onehot) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1'b1);
    end
    // The sample becomes the STABLE_CYCLES-th identical one on this edge
    capture = (state_q == TRACK) && onehot && match && (cnt_q == CNT_LAST);
  end

  // Two-flop synchroniser plus one-cycle history; idle bus reads as all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex_m_q <= '1;
      hex_s_q <= '1;
      hex_p_q <= '1;
      dig_m_q <= '1;
      dig_s_q <= '1;
      dig_p_q <= '1;
    end else begin
      hex_m_q <= bus.hex;
      hex_s_q <= hex_m_q;
      hex_p_q <= hex_s_q;
      dig_m_q <= bus.dig_n;
      dig_s_q <= dig_m_q;
      dig_p_q <= dig_s_q;
    end
  end

  // Capture FSM with registered result bank and pulse outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bcd_q     <= '0;
      valid_q   <= '0;
      upd_q     <= 1'b0;
      err_q     <= 1'b0;
      upd_idx_q <= '0;
      err_cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      upd_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (onehot) state_q <= TRACK;
        end
        TRACK: begin
          if (!onehot) begin
            state_q <= IDLE;
          end else if (capture) begin
            state_q   <= HOLD;
            upd_q     <= 1'b1;
            upd_idx_q <= idx;
            valid_q[idx] <= legal;
            if (legal) begin
              bcd_q[{idx, 2'b00} +: 4] <= code;
            end else begin
              err_q <= 1'b1;
              if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
            end
          end
        end
        HOLD: begin
          // Any change re-arms, so the same value can be captured again after a gap
          if (!match) state_q <= onehot ? TRACK : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.bcd_out = bcd_q;
  assign bus.valid   = valid_q;
  assign bus.upd     = upd_q;
  assign bus.upd_idx = upd_idx_q;
  assign bus.err     = err_q;
  assign bus.err_cnt = err_cnt_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// tb/tb_seg7_scan_capture.sv - scoreboard bench for seg7_scan_capture
module tb_seg7_scan_capture;
  localparam int S = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  seg7_scan_capture_if #(.DIGITS(4), .IDX_W(2)) bus ();

  seg7_scan_capture #(.DIGITS(4), .STABLE_CYCLES(S), .IDX_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [1:0]  idx;
    logic        err;
    logic [15:0] bcd;
    logic [3:0]  vld;
    logic [7:0]  ecnt;
  } exp_t;

  exp_t q[$];

  logic [6:0] pat_tab [12] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0111111, 7'b1111111};
  logic [3:0] code_tab [12] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
                                4'h8, 4'h9, 4'hF, 4'hE};

  // Reference model: the display pins seen as runs of constant value
  logic [10:0] m_cur;
  int          m_start, m_len;
  bit          m_done;
  logic [15:0] m_bcd;
  logic [3:0]  m_vld;
  int          m_ecnt;

  function automatic int lookup(logic [6:0] h);
    for (int i = 0; i < 12; i++) if (pat_tab[i] == h) return i;
    return -1;
  endfunction

  function automatic logic [6:0] rand_illegal();
    logic [6:0] h;
    do h = 7'($urandom); while (lookup(h) >= 0);
    return h;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic model_reset();
    m_cur = 11'h7FF; m_len = 1000; m_done = 1; m_start = 0;
    m_bcd = '0; m_vld = '0; m_ecnt = 0;
  endtask

  // A run of a single one-hot strobe lasting S cycles yields one capture, 2+S edges after it starts
  task automatic model_step(logic [3:0] dig, logic [6:0] hex);
    int zeros, idx, k;
    exp_t e;
    if ({dig, hex} != m_cur) begin
      m_cur = {dig, hex}; m_start = cyc; m_len = 1; m_done = 0;
    end else begin
      m_len++;
    end
    zeros = 0; idx = 0;
    for (int i = 0; i < 4; i++) if (!dig[i]) begin zeros++; idx = i; end
    if (!m_done && m_len == S && zeros == 1) begin
      m_done = 1;
      k = lookup(hex);
      e.err = (k < 0);
      if (k >= 0) begin
        m_bcd[idx*4 +: 4] = code_tab[k];
        m_vld[idx] = 1'b1;
      end else begin
        m_vld[idx] = 1'b0;
        if (m_ecnt < 255) m_ecnt++;
      end
      e.cyc = m_start + 2 + S; e.idx = 2'(idx);
      e.bcd = m_bcd; e.vld = m_vld; e.ecnt = 8'(m_ecnt);
      q.push_back(e);
    end
  endtask

  task automatic drive(logic [3:0] dig, logic [6:0] hex, int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.dig_n = dig; bus.hex = hex;
      model_step(dig, hex);
    end
  endtask

  task automatic idle(int n);
    drive(4'hF, 7'h7F, n);
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_bcd"}, 32'(bus.bcd_out), 32'h0);
    chk({tag, "_valid"}, 32'(bus.valid), 32'h0);
    chk({tag, "_upd"}, 32'(bus.upd), 32'h0);
    chk({tag, "_err"}, 32'(bus.err), 32'h0);
    chk({tag, "_errcnt"}, 32'(bus.err_cnt), 32'h0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; bus.dig_n = 4'hF; bus.hex = 7'h7F;
    q.delete(); model_reset();
    #1 check_zero("reset_async");
    repeat (3) @(posedge clk);
    #1 check_zero("reset_hold");
    rst_n = 1'b1;
  endtask

  // Monitor: every upd must match the oldest expected capture at its predicted cycle
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        tests++; fails++;
        $display("FAIL missing_upd: got none expected upd at cycle %0d", q[0].cyc);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        chk("upd", 32'(bus.upd), 32'h1);
        chk("upd_idx", 32'(bus.upd_idx), 32'(e.idx));
        chk("err", 32'(bus.err), 32'(e.err));
        chk("bcd_out", 32'(bus.bcd_out), 32'(e.bcd));
        chk("valid", 32'(bus.valid), 32'(e.vld));
        chk("err_cnt", 32'(bus.err_cnt), 32'(e.ecnt));
      end else if (bus.upd || bus.err) begin
        tests++; fails++;
        $display("FAIL unexpected_upd: got upd=%0b err=%0b expected 0", bus.upd, bus.err);
      end
    end
  end

  initial begin
    logic [3:0] dig;
    logic [6:0] hex;
    bus.dig_n = 4'hF; bus.hex = 7'h7F;
    model_reset();
    do_reset();

    // T1: single legal capture on digit 0
    drive(4'b1110, 7'b0100100, 10);
    idle(8);

    // T2: full scan 7,1,blank,dash on digits 3..0
    drive(4'b0111, 7'b1111000, 8); idle(2);
    drive(4'b1011, 7'b1111001, 8); idle(2);
    drive(4'b1101, 7'b1111111, 8); idle(2);
    drive(4'b1110, 7'b0111111, 8); idle(8);
    chk("t2_bcd", 32'(bus.bcd_out), 32'h71EF);
    chk("t2_valid", 32'(bus.valid), 32'hF);

    // T3: glitch shorter than the filter, then a held value
    drive(4'b1101, 7'b1111001, 3);
    drive(4'b1101, 7'b0011001, 10);
    idle(8);
    chk("t3_digit1", 32'(bus.bcd_out[7:4]), 32'h4);

    // T4: legal 5 then an illegal pattern on digit 2
    drive(4'b1011, 7'b0010010, 8);
    drive(4'b1011, 7'b1010101, 8);
    idle(8);
    chk("t4_digit2", 32'(bus.bcd_out[11:8]), 32'h5);
    chk("t4_valid2", 32'(bus.valid[2]), 32'h0);
    chk("t4_errcnt", 32'(bus.err_cnt), 32'h1);

    // T5: multi-strobe, long hold, one-cycle gap re-capture
    drive(4'b1100, 7'b0000000, 20);
    drive(4'b0111, 7'b0000000, 50);
    idle(1);
    drive(4'b0111, 7'b0000000, 10);
    idle(8);

    // Randomised runs: glitches, exact-threshold runs, illegal and multi-strobe patterns
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(9) == 0) dig = 4'($urandom);
      else dig = ~(4'b0001 << $urandom_range(3));
      if ($urandom_range(4) == 0) hex = rand_illegal();
      else hex = pat_tab[$urandom_range(11)];
      drive(dig, hex, $urandom_range(1, 8));
      if ($urandom_range(2) != 0) idle($urandom_range(1, 2));
    end
    idle(10);

    // T6: reset while a capture is pending, then err_cnt saturation
    drive(4'b1110, 7'b1000000, 5);
    do_reset();
    idle(10);
    for (int n = 0; n < 260; n++) begin
      drive(~(4'b0001 << $urandom_range(3)), rand_illegal(), S);
      idle(1);
    end
    idle(10);
    chk("t6_errcnt_sat", 32'(bus.err_cnt), 32'd255);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
